// File: rtl/led_ctrl_debounced.sv
// Button-to-LED controller: two-flop synchroniser, per-channel debounce with
// press pulses, toggle latches and a free-running PWM dimmer feeding registered LEDs.
module led_ctrl_debounced #(
  parameter int NUM_CH     = 4,
  parameter int DEB_CYCLES = 4,
  parameter int PWM_BITS   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_CH-1:0]   btn,
  input  logic [1:0]          mode,
  input  logic [PWM_BITS-1:0] duty,
  output logic [NUM_CH-1:0]   btn_db,
  output logic [NUM_CH-1:0]   press_pulse,
  output logic [NUM_CH-1:0]   led
);

  localparam int CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_TOGGLE = 2'b01,
    MODE_PWM    = 2'b10,
    MODE_INVERT = 2'b11
  } mode_e;

  logic [NUM_CH-1:0]             r_sync1, r_sync2;
  logic [NUM_CH-1:0]             r_btn_db, r_pulse, r_tog, r_led;
  logic [NUM_CH-1:0][CNT_W-1:0]  r_cnt;
  logic [PWM_BITS-1:0]           r_pwm_cnt;

  logic [NUM_CH-1:0][CNT_W-1:0]  w_cnt_nxt;
  logic [NUM_CH-1:0]             w_db_nxt, w_pulse_nxt, w_led_nxt;
  logic                          w_pwm_on;

  // All-ones duty means fully on rather than one slot short of it.
  assign w_pwm_on = (duty == '1) || (r_pwm_cnt < duty);

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_db_nxt    = r_btn_db;
    w_pulse_nxt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_sync2[i] == r_btn_db[i]) begin
        w_cnt_nxt[i] = '0;
      end else if (r_cnt[i] == CNT_LAST) begin
        w_cnt_nxt[i]   = '0;
        w_db_nxt[i]    = r_sync2[i];
        w_pulse_nxt[i] = r_sync2[i];
      end else begin
        w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_led_nxt = '0;
    case (mode_e'(mode))
      MODE_DIRECT: w_led_nxt = r_btn_db;
      MODE_TOGGLE: w_led_nxt = r_tog;
      MODE_PWM:    w_led_nxt = r_tog & {NUM_CH{w_pwm_on}};
      MODE_INVERT: w_led_nxt = ~r_btn_db;
      default:     w_led_nxt = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_btn_db  <= '0;
      r_pulse   <= '0;
      r_tog     <= '0;
      r_led     <= '0;
      r_cnt     <= '0;
      r_pwm_cnt <= '0;
    end else begin
      r_sync1   <= btn;
      r_sync2   <= r_sync1;
      r_cnt     <= w_cnt_nxt;
      r_btn_db  <= w_db_nxt;
      r_pulse   <= w_pulse_nxt;
      r_tog     <= r_tog ^ r_pulse;
      r_led     <= w_led_nxt;
      r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
    end
  end

  assign btn_db      = r_btn_db;
  assign press_pulse = r_pulse;
  assign led         = r_led;

endmodule

// File: tb/tb_led_ctrl_debounced.sv
// Bench for led_ctrl_debounced: a behavioural model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_led_ctrl_debounced;

  localparam int N    = 4;
  localparam int DEB  = 4;
  localparam int PB   = 4;
  localparam int PER  = 1 << PB;

  logic          clk = 1'b0;
  logic          clk_en = 1'b0;
  logic          rst_n = 1'b1;
  logic [N-1:0]  btn = '0;
  logic [1:0]    mode = 2'b00;
  logic [PB-1:0] duty = '0;
  logic [N-1:0]  btn_db, press_pulse, led;

  int n_vec = 0;
  int n_err = 0;

  led_ctrl_debounced #(.NUM_CH(N), .DEB_CYCLES(DEB), .PWM_BITS(PB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn         (btn),
    .mode        (mode),
    .duty        (duty),
    .btn_db      (btn_db),
    .press_pulse (press_pulse),
    .led         (led)
  );

  initial forever begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, wanted %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a channel's accepted level flips once the synchronised input has
  // disagreed with it for DEB consecutive edges; the PWM phase is the edge count mod 2^PB.
  logic [N-1:0] m_s1, m_s2, m_db, m_pulse, m_tog, m_led;
  int           m_run [N];
  int           m_phase;

  always @(posedge clk or negedge rst_n) begin : model
    logic [N-1:0] db_n, pulse_n;
    logic         pwm;
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_db = '0; m_pulse = '0; m_tog = '0; m_led = '0;
      m_phase = 0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
    end else begin
      pwm = (int'(duty) == PER - 1) || (m_phase < int'(duty));
      case (mode)
        2'b00:   m_led = m_db;
        2'b01:   m_led = m_tog;
        2'b10:   m_led = pwm ? m_tog : '0;
        default: m_led = ~m_db;
      endcase
      m_tog   = m_tog ^ m_pulse;
      db_n    = m_db;
      pulse_n = '0;
      for (int i = 0; i < N; i++) begin
        m_run[i] = (m_s2[i] != m_db[i]) ? m_run[i] + 1 : 0;
        if (m_run[i] == DEB) begin
          db_n[i]    = ~m_db[i];
          pulse_n[i] = ~m_db[i];
          m_run[i]   = 0;
        end
      end
      m_db    = db_n;
      m_pulse = pulse_n;
      m_s2    = m_s1;
      m_s1    = btn;
      m_phase = (m_phase + 1) % PER;
    end
  end

  always @(negedge clk) begin
    check("model btn_db", 32'(btn_db), 32'(m_db));
    check("model press_pulse", 32'(press_pulse), 32'(m_pulse));
    check("model led", 32'(led), 32'(m_led));
  end

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("reset led", 32'(led), 32'h0);
    check("reset btn_db", 32'(btn_db), 32'h0);
    check("reset press_pulse", 32'(press_pulse), 32'h0);
    edges(2);
    #2 rst_n = 1'b1;
  endtask

  initial begin : stim
    int cnt;
    // Reset with no clock running.
    btn = 4'hF;
    #1 rst_n = 1'b0;
    #1;
    check("noclk led", 32'(led), 32'h0);
    check("noclk btn_db", 32'(btn_db), 32'h0);
    check("noclk press_pulse", 32'(press_pulse), 32'h0);
    btn = 4'h0;
    clk_en = 1'b1;
    edges(2);
    #2 rst_n = 1'b1;

    // Direct mode, latency of debounce and LED.
    edges(2);
    btn = 4'b0101;
    edges(5);
    check("direct btn_db e5", 32'(btn_db), 32'h0);
    edges(1);
    check("direct btn_db e6", 32'(btn_db), 32'b0101);
    check("direct pulse e6", 32'(press_pulse), 32'b0101);
    check("direct led e6", 32'(led), 32'h0);
    edges(1);
    check("direct led e7", 32'(led), 32'b0101);
    check("direct pulse e7", 32'(press_pulse), 32'h0);

    // Glitch rejection on channel 0.
    btn = 4'h0;
    edges(10);
    btn = 4'b0001;
    edges(3);
    btn = 4'h0;
    for (int k = 0; k < 10; k++) begin
      edges(1);
      check("glitch btn_db0", 32'(btn_db[0]), 32'h0);
      check("glitch pulse0", 32'(press_pulse[0]), 32'h0);
      check("glitch led0", 32'(led[0]), 32'h0);
    end

    // Toggle mode, two presses of channel 2.
    do_reset();
    mode = 2'b01;
    edges(3);
    cnt = 0;
    for (int p = 0; p < 2; p++) begin
      btn = 4'b0100;
      for (int k = 0; k < 10; k++) begin edges(1); cnt += int'(press_pulse[2]); end
      btn = 4'h0;
      for (int k = 0; k < 10; k++) begin edges(1); cnt += int'(press_pulse[2]); end
      check("toggle pulses", 32'(cnt), 32'(p + 1));
      check("toggle led", 32'(led), (p == 0) ? 32'b0100 : 32'h0);
    end

    // PWM mode with tog = 0001.
    do_reset();
    mode = 2'b01;
    btn = 4'b0001;
    edges(10);
    btn = 4'h0;
    edges(10);
    check("pwm tog led", 32'(led), 32'b0001);
    mode = 2'b10;
    for (int d = 0; d < 3; d++) begin
      duty = (d == 0) ? 4'd4 : (d == 1) ? 4'd0 : 4'd15;
      edges(2);
      cnt = 0;
      for (int k = 0; k < PER; k++) begin
        edges(1);
        cnt += int'(led[0]);
        check("pwm led[3:1]", 32'(led[3:1]), 32'h0);
      end
      check("pwm on count", 32'(cnt), (d == 0) ? 32'd4 : (d == 1) ? 32'd0 : 32'd16);
    end

    // Inverted mode and asynchronous reset mid-debounce.
    duty = '0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    mode = 2'b11;
    btn = 4'h0;
    edges(2);
    #2 rst_n = 1'b1;
    edges(1);
    check("invert led first edge", 32'(led), 32'hF);
    btn = 4'b0010;
    edges(4);
    check("cnt before reset", 32'(dut.r_cnt[1]), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("async led", 32'(led), 32'h0);
    check("async btn_db", 32'(btn_db), 32'h0);
    check("async tog", 32'(dut.r_tog), 32'h0);
    check("async cnt", 32'(dut.r_cnt[1]), 32'h0);
    edges(2);
    #2 rst_n = 1'b1;
    edges(5);
    check("restart btn_db e5", 32'(btn_db), 32'h0);
    edges(1);
    check("restart btn_db e6", 32'(btn_db), 32'b0010);
    check("restart led e6", 32'(led), 32'hF);
    edges(1);
    check("restart led e7", 32'(led), 32'b1101);

    // Simultaneous presses in toggle mode.
    btn = 4'h0;
    do_reset();
    mode = 2'b01;
    edges(3);
    btn = 4'hF;
    edges(5);
    check("simul pulse e5", 32'(press_pulse), 32'h0);
    edges(1);
    check("simul pulse e6", 32'(press_pulse), 32'hF);
    edges(1);
    check("simul pulse e7", 32'(press_pulse), 32'h0);
    check("simul led e7", 32'(led), 32'h0);
    edges(1);
    check("simul led e8", 32'(led), 32'hF);
    edges(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
